// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family: FSM encoding and conditional negate.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // Widest value the negate helper handles (2 * max operand width).
    localparam int unsigned NEG_W = 64;

    // Two's-complement negate when neg is set; callers truncate to their own width,
    // which is safe because the low bits of -x do not depend on the high bits.
    function automatic logic [NEG_W-1:0] cond_neg(input logic neg, input logic [NEG_W-1:0] x);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mult_cond_neg.sv
// Width-parametrised conditional two's-complement negate.
module mult_cond_neg
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // Negate through the shared helper, then keep only our width.
    always_comb begin
        y = WIDTH'(cond_neg(neg, NEG_W'(x)));
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, unsigned or signed per transaction.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the sign reapplied.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    seq_multiplier_if.slave  bus
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] p_final;
    logic [2*WIDTH-1:0] p_reg;
    logic [WIDTH:0]     sum;

    // Magnitudes of the incoming operands; -2^(W-1) maps to 2^(W-1), still fits unsigned.
    mult_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
        .neg (bus.signed_mode & bus.a[WIDTH-1]),
        .x   (bus.a),
        .y   (a_mag)
    );

    mult_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
        .neg (bus.signed_mode & bus.b[WIDTH-1]),
        .x   (bus.b),
        .y   (b_mag)
    );

    // Sign correction of the final accumulator value.
    mult_cond_neg #(.WIDTH(2 * WIDTH)) u_neg_p (
        .neg (neg),
        .x   (acc_next),
        .y   (p_final)
    );

    // One shift-add step: add into the upper half with carry, then shift right.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: operand capture in IDLE, iteration in CALC, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            count  <= '0;
            acc    <= '0;
            p_reg  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        count  <= '0;
                        acc    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) begin
                        p_reg <= p_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.p         = p_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH = 2, 8 and 16.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2;
    logic rst8;
    logic rst16;

    seq_multiplier_if #(.WIDTH(2))  bus2 ();
    seq_multiplier_if #(.WIDTH(8))  bus8 ();
    seq_multiplier_if #(.WIDTH(16)) bus16 ();

    seq_multiplier #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst2),  .bus(bus2.slave));
    seq_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(bus8.slave));
    seq_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst16), .bus(bus16.slave));

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] p;
    } vec8_t;

    vec8_t v8 [10];

    logic [63:0] expq [$];
    int          got;
    localparam int N16 = 40;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference product: sign- or zero-extend, multiply, keep 2*w bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm, input int w);
        longint sa;
        longint sb;
        longint pr;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One WIDTH=8 transaction; returns product and cycles from accept edge to out_valid.
    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output logic [15:0] p, output int lat);
        check("w8 in_ready before accept", 64'(bus8.in_ready), 64'd1);
        bus8.a           = a;
        bus8.b           = b;
        bus8.signed_mode = sm;
        bus8.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid    = 1'b0;
        bus8.a           = ~a;
        bus8.b           = ~b;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = bus8.p;
    endtask

    initial begin
        logic [15:0] p8;
        int          lat;
        int          extra;

        v8[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        v8[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        v8[2] = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
        v8[3] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        v8[4] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
        v8[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        v8[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        v8[7] = '{8'd12, 8'd13, 1'b0, 16'h009C};
        v8[8] = '{8'hF6, 8'h07, 1'b1, 16'hFFBA};
        v8[9] = '{8'h07, 8'hF6, 1'b0, 16'h06BA};

        {bus2.in_valid, bus2.a, bus2.b, bus2.signed_mode}     = '0;
        {bus8.in_valid, bus8.a, bus8.b, bus8.signed_mode}     = '0;
        {bus16.in_valid, bus16.a, bus16.b, bus16.signed_mode} = '0;
        bus2.out_ready  = 1'b1;
        bus8.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        rst2 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;

        #17;
        check("reset in_ready",  64'(bus8.in_ready),  64'd1);
        check("reset out_valid", 64'(bus8.out_valid), 64'd0);
        check("reset busy",      64'(bus8.busy),      64'd0);
        check("reset p",         64'(bus8.p),         64'd0);
        rst2 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
        @(posedge clk); #1;

        // Table-driven WIDTH=8 vectors with out_ready held high.
        for (int i = 0; i < 10; i++) begin
            mul8(v8[i].a, v8[i].b, v8[i].sm, p8, lat);
            check($sformatf("w8 p vec%0d", i), 64'(p8), 64'(v8[i].p));
            check($sformatf("w8 latency vec%0d", i), 64'(lat), 64'd8);
            @(posedge clk); #1;
            check($sformatf("w8 in_ready after vec%0d", i), 64'(bus8.in_ready), 64'd1);
            check($sformatf("w8 out_valid drop vec%0d", i), 64'(bus8.out_valid), 64'd0);
        end

        // Back-pressure, with stray in_valid pulses in CALC and DONE.
        bus8.out_ready   = 1'b0;
        bus8.a           = 8'd5;
        bus8.b           = 8'd6;
        bus8.signed_mode = 1'b0;
        bus8.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus8.a = 8'd9; bus8.b = 8'd9; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 3;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 64'(lat), 64'd8);
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid hold", 64'(bus8.out_valid), 64'd1);
            check("bp p hold",         64'(bus8.p),         64'd30);
            check("bp in_ready low",   64'(bus8.in_ready),  64'd0);
            check("bp busy high",      64'(bus8.busy),      64'd1);
            @(posedge clk); #1;
        end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check("bp release out_valid", 64'(bus8.out_valid), 64'd0);
        check("bp release in_ready",  64'(bus8.in_ready),  64'd1);
        check("bp release busy",      64'(bus8.busy),      64'd0);
        check("bp p retained",        64'(bus8.p),         64'd30);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.out_valid || bus8.busy) extra++;
        end
        check("bp no second result", 64'(extra), 64'd0);

        // Asynchronous reset three cycles into CALC.
        bus8.a = 8'd100; bus8.b = 8'd100; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst busy before", 64'(bus8.busy), 64'd1);
        #2 rst8 = 1'b1;
        #1;
        check("rst async out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst async busy",      64'(bus8.busy),      64'd0);
        check("rst async p",         64'(bus8.p),         64'd0);
        check("rst async in_ready",  64'(bus8.in_ready),  64'd1);
        #1 rst8 = 1'b0;
        @(posedge clk); #1;
        mul8(8'd3, 8'd3, 1'b0, p8, lat);
        check("post-rst p",       64'(p8),  64'd9);
        check("post-rst latency", 64'(lat), 64'd8);
        @(posedge clk); #1;

        // Exhaustive WIDTH=2 in both modes.
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    bus2.a           = 2'(a);
                    bus2.b           = 2'(b);
                    bus2.signed_mode = sm[0];
                    bus2.in_valid    = 1'b1;
                    @(posedge clk); #1;
                    bus2.in_valid = 1'b0;
                    lat = 0;
                    while (!bus2.out_valid && lat < 20) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check($sformatf("w2 p sm%0d %0dx%0d", sm, a, b), 64'(bus2.p),
                          model(32'(a), 32'(b), sm[0], 2));
                    check($sformatf("w2 latency sm%0d %0dx%0d", sm, a, b), 64'(lat), 64'd2);
                    @(posedge clk); #1;
                end
            end
        end

        // WIDTH=16 random stream with random consumer back-pressure.
        got = 0;
        fork
            begin
                for (int i = 0; i < N16; i++) begin
                    logic [15:0] ra;
                    logic [15:0] rb;
                    logic        rs;
                    int          w;
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    w  = 0;
                    while (!bus16.in_ready && w < 200) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 200) begin
                        ntot++;
                        $display("FAIL w16 in_ready timeout: got 0, expected 1");
                    end
                    bus16.a           = ra;
                    bus16.b           = rb;
                    bus16.signed_mode = rs;
                    bus16.in_valid    = 1'b1;
                    expq.push_back(model(32'(ra), 32'(rb), rs, 16));
                    @(posedge clk); #1;
                    bus16.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (got < N16 && cyc < 5000) begin
                    @(posedge clk); #1;
                    cyc++;
                    bus16.out_ready = 1'($urandom_range(0, 1));
                    if (bus16.out_valid && bus16.out_ready) begin
                        if (expq.size() == 0) begin
                            ntot++;
                            $display("FAIL w16 unexpected result: got %0h, expected none",
                                     bus16.p);
                        end else begin
                            check($sformatf("w16 p #%0d", got), 64'(bus16.p), expq.pop_front());
                        end
                        got++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        bus16.out_ready = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("w16 results received", 64'(got), 64'(N16));
        check("w16 none outstanding", 64'(expq.size()), 64'd0);
        check("w16 no extra result",  64'(bus16.out_valid), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
